// File: rtl/ctu_rst_seq_pkg.sv
// ctu_rst_seq_pkg
// Shared definitions for the cluster reset/clock-enable sequencer:
//   - seq_state_e : sequencer state encoding
//   - DEF_*       : default parameter values
//   - max_hold()  : largest hold/stagger count, used to size-check CNT_W
package ctu_rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RAMP     = 3'd1,
    ST_RST_HOLD = 3'd2,
    ST_RUN      = 3'd3,
    ST_WARM     = 3'd4,
    ST_DBG      = 3'd5
  } seq_state_e;

  localparam int DEF_NUM_CLUSTERS = 8;
  localparam int DEF_STAGGER_CYC  = 4;
  localparam int DEF_RST_HOLD_CYC = 16;
  localparam int DEF_DBG_HOLD_CYC = 8;
  localparam int DEF_CNT_W        = 8;

  function automatic int max_hold(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/ctu_cluster_rst_seq_timer.sv
// ctu_seq_timer
// Loadable down-counter shared by every timed phase of the sequencer.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load load_val_i this cycle (wins over counting)
//   load_val_i    : number of cycles until done_o (>=1)
//   done_o        : high while the count sits at 1 (terminal count)
// A load of L at edge X makes done_o visible after edge X+L-1, so the owner
// acts on it at edge X+L. Count saturates at 0, never wraps.
module ctu_seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = load_val_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/ctu_cluster_rst_seq.sv
// ctu_cluster_rst_seq
// Power-on clock-enable ramp, global reset release, and warm-reset /
// debug-init request servicing for the per-cluster header lines.
// Ports:
//   gclk, rst        : clock, synchronous active-high reset
//   por_done         : power-on complete (sampled only in IDLE)
//   cluster_en_mask  : per-cluster run permission
//   warm_rst_req     : warm-reset request, level, held until ack
//   dbg_init_req     : debug-init request, level, held until ack
//   req_ack          : one-cycle grant pulse
//   ack_is_warm      : qualifies req_ack (1 = warm, 0 = debug-init)
//   cluster_cken     : per-cluster clock enable
//   grst_l           : global reset, active low
//   gdbginit_l       : global debug init, active low
//   seq_busy         : high outside RUN
// The FSM reacts at the sampling edge; all outputs are registered from the
// current state, so every visible effect lands one edge after the decision.
module ctu_cluster_rst_seq
  import ctu_rst_seq_pkg::*;
#(
  parameter int NUM_CLUSTERS = DEF_NUM_CLUSTERS,
  parameter int STAGGER_CYC  = DEF_STAGGER_CYC,
  parameter int RST_HOLD_CYC = DEF_RST_HOLD_CYC,
  parameter int DBG_HOLD_CYC = DEF_DBG_HOLD_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic                    gclk,
  input  logic                    rst,
  input  logic                    por_done,
  input  logic [NUM_CLUSTERS-1:0] cluster_en_mask,
  input  logic                    warm_rst_req,
  input  logic                    dbg_init_req,
  output logic                    req_ack,
  output logic                    ack_is_warm,
  output logic [NUM_CLUSTERS-1:0] cluster_cken,
  output logic                    grst_l,
  output logic                    gdbginit_l,
  output logic                    seq_busy
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_RAMP     = ST_RAMP;
  localparam logic [2:0] S_RST_HOLD = ST_RST_HOLD;
  localparam logic [2:0] S_RUN      = ST_RUN;
  localparam logic [2:0] S_WARM     = ST_WARM;
  localparam logic [2:0] S_DBG      = ST_DBG;

  localparam int SLOT_W = (NUM_CLUSTERS > 1) ? $clog2(NUM_CLUSTERS) : 1;
  localparam logic [SLOT_W-1:0]       LAST_SLOT = SLOT_W'(NUM_CLUSTERS - 1);
  localparam logic [NUM_CLUSTERS-1:0] ONE_HOT0  = NUM_CLUSTERS'(1);

  if ((max_hold(STAGGER_CYC, RST_HOLD_CYC, DBG_HOLD_CYC) >> CNT_W) != 0) begin : g_cnt_w_chk
    $error("CNT_W too narrow for STAGGER_CYC/RST_HOLD_CYC/DBG_HOLD_CYC");
  end
  if (STAGGER_CYC < 1 || RST_HOLD_CYC < 1 || DBG_HOLD_CYC < 1) begin : g_hold_chk
    $error("hold/stagger parameters must be >= 1");
  end

  // ---------------- sequencing state ----------------
  logic [2:0]              state_q, state_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic [NUM_CLUSTERS-1:0] ramp_q, ramp_d;   // clusters whose slot has begun
  logic                    grant_q, grant_d;
  logic                    grant_warm_q, grant_warm_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;

  ctu_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i      (gclk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    ramp_d       = ramp_q;
    grant_d      = 1'b0;
    grant_warm_d = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    case (state_q)
      S_IDLE: begin
        if (por_done) begin
          state_d  = S_RAMP;
          slot_d   = '0;
          ramp_d   = ONE_HOT0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(STAGGER_CYC);
        end
      end
      S_RAMP: begin
        // Masked clusters still burn their slot so the release time is fixed.
        if (tmr_done) begin
          tmr_load = 1'b1;
          if (slot_q == LAST_SLOT) begin
            state_d = S_RST_HOLD;
            tmr_val = CNT_W'(RST_HOLD_CYC);
          end else begin
            slot_d  = slot_q + 1'b1;
            ramp_d  = ramp_q | (ONE_HOT0 << slot_d);
            tmr_val = CNT_W'(STAGGER_CYC);
          end
        end
      end
      S_RST_HOLD: begin
        if (tmr_done) state_d = S_RUN;
      end
      S_RUN: begin
        // Warm has priority; a concurrent debug request stays pending.
        if (warm_rst_req) begin
          state_d      = S_WARM;
          grant_d      = 1'b1;
          grant_warm_d = 1'b1;
          tmr_load     = 1'b1;
          tmr_val      = CNT_W'(RST_HOLD_CYC);
        end else if (dbg_init_req) begin
          state_d  = S_DBG;
          grant_d  = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(DBG_HOLD_CYC);
        end
      end
      S_WARM, S_DBG: begin
        if (tmr_done) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      ramp_q       <= '0;
      grant_q      <= 1'b0;
      grant_warm_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      ramp_q       <= ramp_d;
      grant_q      <= grant_d;
      grant_warm_q <= grant_warm_d;
    end
  end

  // ---------------- registered outputs ----------------
  logic [NUM_CLUSTERS-1:0] cken_q, cken_d;
  logic grst_q, grst_d, gdbg_q, gdbg_d, ack_q, ack_d, ackw_q, ackw_d, busy_q, busy_d;

  always_comb begin
    cken_d = cken_q;
    case (state_q)
      S_IDLE:             cken_d = '0;
      S_RAMP, S_RST_HOLD: cken_d = ramp_q & cluster_en_mask;
      S_RUN:              cken_d = cluster_en_mask;
      default:            cken_d = cken_q;  // frozen across warm/debug holds
    endcase
    grst_d = (state_q == S_RUN) || (state_q == S_DBG);
    gdbg_d = (state_q == S_RUN);
    busy_d = (state_q != S_RUN);
    ack_d  = grant_q;
    ackw_d = grant_q & grant_warm_q;
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      cken_q <= '0;
      grst_q <= 1'b0;
      gdbg_q <= 1'b0;
      ack_q  <= 1'b0;
      ackw_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      cken_q <= cken_d;
      grst_q <= grst_d;
      gdbg_q <= gdbg_d;
      ack_q  <= ack_d;
      ackw_q <= ackw_d;
      busy_q <= busy_d;
    end
  end

  assign cluster_cken = cken_q;
  assign grst_l       = grst_q;
  assign gdbginit_l   = gdbg_q;
  assign req_ack      = ack_q;
  assign ack_is_warm  = ackw_q;
  assign seq_busy     = busy_q;

endmodule

// File: tb/tb_ctu_cluster_rst_seq.sv
// Bench for ctu_cluster_rst_seq: directed phases with randomized gaps,
// masks and request mixes, checked each cycle against an event-time model.
module tb_ctu_cluster_rst_seq;
  localparam int NC = 8, SC = 4, RH = 16, DH = 8;

  logic gclk = 1'b0;
  logic rst, por_done, warm_rst_req, dbg_init_req;
  logic [NC-1:0] cluster_en_mask, cluster_cken;
  logic req_ack, ack_is_warm, grst_l, gdbginit_l, seq_busy;

  always #5 gclk = ~gclk;

  ctu_cluster_rst_seq dut (
    .gclk(gclk), .rst(rst), .por_done(por_done), .cluster_en_mask(cluster_en_mask),
    .warm_rst_req(warm_rst_req), .dbg_init_req(dbg_init_req), .req_ack(req_ack),
    .ack_is_warm(ack_is_warm), .cluster_cken(cluster_cken), .grst_l(grst_l),
    .gdbginit_l(gdbginit_l), .seq_busy(seq_busy)
  );

  int checks = 0, errors = 0, cyc = 0;

  // Model: expected outputs after each edge, derived from event times.
  logic [NC-1:0] e_cken = '0;
  logic e_grst = 0, e_gdbg = 0, e_ack = 0, e_warm = 0, e_busy = 1;
  bit m_idle = 1, m_granted = 0, m_kind_warm = 0;
  int m_T = 0, m_resume = 0, m_gedge = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cyc=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (rst) begin
      e_cken = '0; e_grst = 0; e_gdbg = 0; e_ack = 0; e_warm = 0; e_busy = 1;
      m_idle = 1; m_granted = 0;
    end else if (m_idle) begin
      if (por_done) begin
        m_idle = 0; m_granted = 0; m_T = cyc;
        m_resume = cyc + NC*SC + RH + 1;  // first edge that samples requests
      end
    end else begin
      e_ack = 0; e_warm = 0;
      if (cyc >= m_resume) begin
        e_cken = cluster_en_mask; e_grst = 1; e_gdbg = 1; e_busy = 0; m_granted = 0;
        if (warm_rst_req) begin
          m_granted = 1; m_kind_warm = 1; m_gedge = cyc; m_resume = cyc + 1 + RH;
        end else if (dbg_init_req) begin
          m_granted = 1; m_kind_warm = 0; m_gedge = cyc; m_resume = cyc + 1 + DH;
        end
      end else if (!m_granted) begin
        for (int i = 0; i < NC; i++)
          e_cken[i] = (cyc >= m_T + 1 + i*SC) && cluster_en_mask[i];
      end else if (cyc == m_gedge + 1) begin
        e_ack = 1; e_warm = m_kind_warm; e_busy = 1;
        e_gdbg = 0; e_grst = !m_kind_warm;
      end
    end
  endtask

  task automatic step();
    @(posedge gclk);
    model_edge();
    @(negedge gclk);
    chk("cken", 32'(cluster_cken), 32'(e_cken));
    chk("grst_l", 32'(grst_l), 32'(e_grst));
    chk("gdbginit_l", 32'(gdbginit_l), 32'(e_gdbg));
    chk("req_ack", 32'(req_ack), 32'(e_ack));
    chk("ack_is_warm", 32'(req_ack & ack_is_warm), 32'(e_ack & e_warm));
    chk("seq_busy", 32'(seq_busy), 32'(e_busy));
    if (req_ack) begin
      if (ack_is_warm) warm_rst_req = 0;
      else             dbg_init_req = 0;
    end
  endtask

  initial begin
    int T, E, first0, first7, rise, lowcnt, ack2, ackc;
    logic grst_all;
    logic [NC-1:0] orc;
    rst = 1; por_done = 0; warm_rst_req = 0; dbg_init_req = 0; cluster_en_mask = 8'hFF;
    repeat (3) step();
    chk("reset_vals", {cluster_cken, grst_l, gdbginit_l, req_ack, ack_is_warm, seq_busy},
        {8'h00, 5'b00001});
    rst = 0;
    repeat (4) step();

    // Power-on with all clusters permitted
    por_done = 1; T = cyc + 1; step(); por_done = 0;
    first0 = -1; first7 = -1; rise = -1;
    for (int k = 0; k < 80 && rise < 0; k++) begin
      step();
      if (first0 < 0 && cluster_cken[0]) first0 = cyc;
      if (first7 < 0 && cluster_cken[7]) first7 = cyc;
      if (rise < 0 && grst_l && gdbginit_l) rise = cyc;
    end
    chk("cken0_rise", first0, T + 1);
    chk("cken7_rise", first7, T + 29);
    chk("release", rise, T + 49);

    // Single debug-init
    repeat ($urandom_range(1, 5)) step();
    dbg_init_req = 1; E = cyc + 1; step(); step();
    chk("dbg_ack", {req_ack, ack_is_warm}, 2'b10);
    lowcnt = gdbginit_l ? 0 : 1; grst_all = grst_l;
    for (int k = 0; k < 40 && !gdbginit_l; k++) begin
      step();
      if (!gdbginit_l) lowcnt++;
      grst_all &= grst_l;
    end
    chk("dbg_low_len", lowcnt, DH);
    chk("dbg_grst_high", grst_all, 1);

    // Simultaneous warm + debug
    repeat ($urandom_range(1, 5)) step();
    warm_rst_req = 1; dbg_init_req = 1; E = cyc + 1; step(); step();
    chk("warm_ack", {req_ack, ack_is_warm}, 2'b11);
    lowcnt = grst_l ? 0 : 1; ack2 = -1;
    for (int k = 0; k < 60 && ack2 < 0; k++) begin
      step();
      if (!grst_l) lowcnt++;
      if (req_ack) ack2 = cyc;
    end
    chk("warm_low_len", lowcnt, RH);
    chk("dbg_after_warm_ack", ack2, E + RH + 2);
    repeat (DH + 2) step();

    // Randomized run-mode traffic and mask changes
    for (int it = 0; it < 40; it++) begin
      int r;
      repeat ($urandom_range(0, 6)) step();
      if ($urandom_range(0, 2) == 0) cluster_en_mask = NC'($urandom);
      r = $urandom_range(0, 3);
      if (r[0]) warm_rst_req = 1;
      if (r[1]) dbg_init_req = 1;
      repeat ($urandom_range(1, 25)) step();
    end
    for (int k = 0; k < 200 && (warm_rst_req || dbg_init_req || seq_busy); k++) step();
    chk("drained", {warm_rst_req, dbg_init_req, seq_busy}, 3'b000);

    // Reset in the middle of a warm hold
    warm_rst_req = 1; step(); step();
    repeat (5) step();
    rst = 1; step(); rst = 0;
    chk("rst_midwarm", {cluster_cken, grst_l, gdbginit_l, req_ack, ack_is_warm, seq_busy},
        {8'h00, 5'b00001});
    repeat (3) step();

    // Masked ramp with a warm request pending during RAMP
    cluster_en_mask = 8'hA5; por_done = 1; T = cyc + 1; step(); por_done = 0;
    repeat ($urandom_range(2, 20)) step();
    warm_rst_req = 1;
    orc = '0; rise = -1; ackc = -1;
    for (int k = 0; k < 100 && ackc < 0; k++) begin
      step();
      orc |= cluster_cken;
      if (rise < 0 && grst_l) rise = cyc;
      if (req_ack) ackc = cyc;
    end
    chk("a5_masked_bits", 32'(orc & 8'h5A), 0);
    chk("a5_release", rise, T + 49);
    chk("warm_in_ramp_ack", ackc, T + 50);
    repeat (RH + 2) step();
    cluster_en_mask = 8'h0F; step();
    chk("mask_track", 32'(cluster_cken), 32'h0F);
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
